// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised array behind the dmem req/ack port.
// Accepts one request at a time, inserts WAIT_STATES wait cycles, then acks for one cycle.
module dmem_responder #(
  parameter int unsigned MEM_ADDR_WIDTH = 16,
  parameter int unsigned MEM_DATA_WIDTH = 16,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned WAIT_STATES    = 2
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic                      dmem_req_i,
  input  logic                      dmem_we_i,
  input  logic [MEM_ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [MEM_DATA_WIDTH-1:0] dmem_wdata_i,
  output logic [MEM_DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                      dmem_ack_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  state_t                    state;
  logic [3:0]                cnt;
  logic                      lat_we;
  logic [IDX_W-1:0]          lat_idx;
  logic [MEM_DATA_WIDTH-1:0] lat_wdata;
  logic [MEM_DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]          req_idx;
  logic                      unused_addr_bits;

  // Byte address to word index; bit 0 and bits above the index are dropped.
  assign req_idx          = dmem_addr_i[IDX_W:1];
  assign unused_addr_bits = ^dmem_addr_i;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      lat_we       <= 1'b0;
      lat_idx      <= '0;
      lat_wdata    <= '0;
      dmem_ack_o   <= 1'b0;
      dmem_rdata_o <= '0;
    end else begin
      dmem_ack_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dmem_req_i) begin
            lat_we    <= dmem_we_i;
            lat_idx   <= req_idx;
            lat_wdata <= dmem_wdata_i;
            cnt       <= WS;
            // Zero wait states: ack and read data are produced straight from the live request.
            if (WAIT_STATES == 0) begin
              state      <= ST_ACK;
              dmem_ack_o <= 1'b1;
              if (!dmem_we_i) dmem_rdata_o <= mem[req_idx];
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!dmem_req_i) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state      <= ST_ACK;
              dmem_ack_o <= 1'b1;
              if (!lat_we) dmem_rdata_o <= mem[lat_idx];
            end
          end
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Array is deliberately outside the reset domain; writes commit at the edge ending ACK.
  always_ff @(posedge clk_i) begin
    if (state == ST_ACK && lat_we) mem[lat_idx] <= lat_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH=256, WAIT_STATES=2).
module tb_dmem_responder;

  logic        clk_i = 1'b0;
  logic        arst_ni = 1'b0;
  logic        dmem_req_i = 1'b0;
  logic        dmem_we_i = 1'b0;
  logic [15:0] dmem_addr_i = '0;
  logic [15:0] dmem_wdata_i = '0;
  logic [15:0] dmem_rdata_o;
  logic        dmem_ack_o;

  int checks = 0;
  int errors = 0;

  localparam logic        B2B_WE   [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [15:0] B2B_ADDR [8] = '{16'h0100, 16'h0100, 16'h0100, 16'h0102,
                                           16'h0102, 16'h0104, 16'h0106, 16'h0106};
  localparam logic [15:0] B2B_WD   [8] = '{16'h0000, 16'h0A0A, 16'h0000, 16'h1B1B,
                                           16'h0000, 16'h2C2C, 16'h0000, 16'h3D3D};
  localparam logic [15:0] B2B_RD   [8] = '{16'hA000, 16'hA000, 16'h0A0A, 16'h0A0A,
                                           16'h1B1B, 16'h1B1B, 16'hA003, 16'hA003};

  dmem_responder #(
    .MEM_ADDR_WIDTH(16),
    .MEM_DATA_WIDTH(16),
    .DEPTH(256),
    .WAIT_STATES(2)
  ) dut (
    .clk_i(clk_i),
    .arst_ni(arst_ni),
    .dmem_req_i(dmem_req_i),
    .dmem_we_i(dmem_we_i),
    .dmem_addr_i(dmem_addr_i),
    .dmem_wdata_i(dmem_wdata_i),
    .dmem_rdata_o(dmem_rdata_o),
    .dmem_ack_o(dmem_ack_o)
  );

  always #5 clk_i = ~clk_i;

  // Stimulus only: one full transfer, returns ack latency (-1 on timeout) and ack-cycle rdata.
  task automatic do_xfer(input logic w, input logic [15:0] a, input logic [15:0] d,
                         output int lat, output logic [15:0] rd);
    dmem_we_i = w; dmem_addr_i = a; dmem_wdata_i = d; dmem_req_i = 1'b1;
    @(posedge clk_i); #1;
    lat = 1;
    while (dmem_ack_o !== 1'b1 && lat < 20) begin
      @(posedge clk_i); #1;
      lat++;
    end
    rd = dmem_rdata_o;
    if (dmem_ack_o !== 1'b1) lat = -1;
    dmem_req_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    arst_ni = 1'b0; dmem_req_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (dmem_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", dmem_ack_o); end
    checks++;
    if (dmem_rdata_o !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", dmem_rdata_o); end
    arst_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (dmem_ack_o !== 1'b0 || dmem_rdata_o !== 16'h0000) begin
        errors++;
        $display("FAIL idle_after_reset cycle %0d: ack=%b rdata=%h expected ack=0 rdata=0000", i, dmem_ack_o, dmem_rdata_o);
      end
    end
  endtask

  task automatic test_write_read();
    int lat; logic [15:0] rd;
    do_xfer(1'b1, 16'h0010, 16'hBEEF, lat, rd);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL write_latency: got %0d expected 3", lat); end
    do_xfer(1'b0, 16'h0010, 16'h0000, lat, rd);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL read_latency: got %0d expected 3", lat); end
    checks++;
    if (rd !== 16'hBEEF) begin errors++; $display("FAIL read_data: got %h expected beef", rd); end
  endtask

  task automatic test_alias();
    int lat; logic [15:0] rd;
    do_xfer(1'b1, 16'h0202, 16'h1234, lat, rd);
    do_xfer(1'b0, 16'h0003, 16'h0000, lat, rd);
    checks++;
    if (lat != 3 || rd !== 16'h1234) begin errors++; $display("FAIL alias_0003: lat=%0d rdata=%h expected lat=3 rdata=1234", lat, rd); end
    do_xfer(1'b0, 16'h0203, 16'h0000, lat, rd);
    checks++;
    if (rd !== 16'h1234) begin errors++; $display("FAIL alias_0203: got %h expected 1234", rd); end
    do_xfer(1'b0, 16'hFE03, 16'h0000, lat, rd);
    checks++;
    if (rd !== 16'h1234) begin errors++; $display("FAIL alias_fe03: got %h expected 1234", rd); end
  endtask

  task automatic test_abort();
    int lat; logic [15:0] rd; logic seen;
    do_xfer(1'b1, 16'h0020, 16'h0000, lat, rd);
    dmem_we_i = 1'b1; dmem_addr_i = 16'h0020; dmem_wdata_i = 16'hAAAA; dmem_req_i = 1'b1;
    @(posedge clk_i); #1;
    dmem_req_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (dmem_ack_o !== 1'b0) seen = 1'b1;
      @(posedge clk_i); #1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL abort_no_ack: got ack=1 expected no ack"); end
    do_xfer(1'b0, 16'h0020, 16'h0000, lat, rd);
    checks++;
    if (lat != 3 || rd !== 16'h0000) begin errors++; $display("FAIL abort_no_write: lat=%0d rdata=%h expected lat=3 rdata=0000", lat, rd); end
  endtask

  task automatic test_stability();
    int lat; logic [15:0] rd;
    do_xfer(1'b1, 16'h0042, 16'h4242, lat, rd);
    dmem_we_i = 1'b1; dmem_addr_i = 16'h0040; dmem_wdata_i = 16'h1111; dmem_req_i = 1'b1;
    @(posedge clk_i); #1;
    dmem_we_i = 1'b0; dmem_addr_i = 16'h0042; dmem_wdata_i = 16'h2222;
    lat = 1;
    while (dmem_ack_o !== 1'b1 && lat < 20) begin @(posedge clk_i); #1; lat++; end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL stable_latency: got %0d expected 3", lat); end
    dmem_req_i = 1'b0;
    @(posedge clk_i); #1;
    do_xfer(1'b0, 16'h0040, 16'h0000, lat, rd);
    checks++;
    if (rd !== 16'h1111) begin errors++; $display("FAIL stable_latched_write: got %h expected 1111", rd); end
    do_xfer(1'b0, 16'h0042, 16'h0000, lat, rd);
    checks++;
    if (rd !== 16'h4242) begin errors++; $display("FAIL stable_other_addr: got %h expected 4242", rd); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] rd;
    int cyc; int n_ack; logic prev;
    for (int i = 0; i < 4; i++)
      do_xfer(1'b1, 16'h0100 + 16'(2 * i), 16'hA000 + 16'(i), lat, rd);
    cyc = 0; n_ack = 0; prev = 1'b0;
    dmem_we_i = B2B_WE[0]; dmem_addr_i = B2B_ADDR[0]; dmem_wdata_i = B2B_WD[0]; dmem_req_i = 1'b1;
    while (n_ack < 8 && cyc < 60) begin
      @(posedge clk_i); #1;
      cyc++;
      checks++;
      if (dmem_ack_o === 1'b1 && prev) begin errors++; $display("FAIL b2b_double_ack: ack high two cycles at cycle %0d", cyc); end
      prev = dmem_ack_o;
      if (dmem_ack_o === 1'b1) begin
        checks++;
        if (cyc != 3 + 4 * n_ack) begin errors++; $display("FAIL b2b_spacing op %0d: ack at cycle %0d expected %0d", n_ack, cyc, 3 + 4 * n_ack); end
        checks++;
        if (dmem_rdata_o !== B2B_RD[n_ack]) begin errors++; $display("FAIL b2b_rdata op %0d: got %h expected %h", n_ack, dmem_rdata_o, B2B_RD[n_ack]); end
        n_ack++;
        if (n_ack < 8) begin
          dmem_we_i = B2B_WE[n_ack]; dmem_addr_i = B2B_ADDR[n_ack]; dmem_wdata_i = B2B_WD[n_ack];
        end else begin
          dmem_req_i = 1'b0;
        end
      end
    end
    checks++;
    if (n_ack != 8) begin errors++; $display("FAIL b2b_timeout: got %0d acks expected 8", n_ack); end
    @(posedge clk_i); #1;
    checks++;
    if (dmem_ack_o !== 1'b0) begin errors++; $display("FAIL b2b_trailing_ack: got %b expected 0", dmem_ack_o); end
    @(posedge clk_i); #1;
    do_xfer(1'b0, 16'h0104, 16'h0000, lat, rd);
    checks++;
    if (rd !== 16'h2C2C) begin errors++; $display("FAIL b2b_final_a2: got %h expected 2c2c", rd); end
    do_xfer(1'b0, 16'h0106, 16'h0000, lat, rd);
    checks++;
    if (rd !== 16'h3D3D) begin errors++; $display("FAIL b2b_final_a3: got %h expected 3d3d", rd); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] rd;
    do_xfer(1'b1, 16'h0030, 16'h7777, lat, rd);
    dmem_we_i = 1'b1; dmem_addr_i = 16'h0030; dmem_wdata_i = 16'h5555; dmem_req_i = 1'b1;
    @(posedge clk_i); #3;
    arst_ni = 1'b0;
    #1;
    checks++;
    if (dmem_ack_o !== 1'b0 || dmem_rdata_o !== 16'h0000) begin
      errors++; $display("FAIL reset_in_wait: ack=%b rdata=%h expected ack=0 rdata=0000", dmem_ack_o, dmem_rdata_o);
    end
    dmem_req_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1; arst_ni = 1'b1;
    @(posedge clk_i); #1;
    // Second abort lands inside the ack cycle: ack must drop without waiting for a clock.
    dmem_req_i = 1'b1;
    lat = 0;
    while (dmem_ack_o !== 1'b1 && lat < 20) begin @(posedge clk_i); #1; lat++; end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL reset_ack_latency: got %0d expected 3", lat); end
    #2; arst_ni = 1'b0;
    #1;
    checks++;
    if (dmem_ack_o !== 1'b0) begin errors++; $display("FAIL reset_in_ack: got ack=%b expected 0", dmem_ack_o); end
    dmem_req_i = 1'b0;
    @(posedge clk_i); #1;
    arst_ni = 1'b1;
    @(posedge clk_i); #1;
    do_xfer(1'b0, 16'h0030, 16'h0000, lat, rd);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL reset_new_request: lat=%0d expected 3", lat); end
    checks++;
    if (rd !== 16'h7777) begin errors++; $display("FAIL reset_no_write: got %h expected 7777", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alias();
    test_abort();
    test_stability();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
